// File: rtl/instruction_fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage: FSM state codes,
// next-PC select codes and the branch offset expansion.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_S = 2'd0,
        EXEC_S  = 2'd1,
        HALT_S  = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JREG   = 2'd3
    } npc_sel_t;

    localparam int unsigned TIMER_W = 8;

    // Word offset to byte offset: sign-extend and scale by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_next_pc_calc.sv
// Combinational next-PC selection from the decoder's redirect outputs.
// Register jumps win over absolute jumps, which win over taken branches.
module instruction_fetch_next_pc_calc
    import instruction_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        is_jump,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic        is_jump_reg,
    input  logic [31:0] jump_reg_target,
    input  logic [15:0] imm16,
    input  logic [25:0] addr26,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    npc_sel_t npc_sel;

    always_comb begin
        npc_sel = NPC_SEQ;
        if (is_jump_reg) begin
            npc_sel = NPC_JREG;
        end else if (is_jump) begin
            npc_sel = NPC_JUMP;
        end else if (is_branch && branch_taken) begin
            npc_sel = NPC_BRANCH;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        case (npc_sel)
            NPC_JREG:   next_pc = jump_reg_target;
            NPC_JUMP:   next_pc = {pc_plus4[31:28], addr26, 2'b00};
            NPC_BRANCH: next_pc = pc_plus4 + branch_offset(imm16);
            default:    next_pc = pc_plus4;
        endcase
    end

    // Only a register jump can produce a non-word-aligned target.
    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches one word at a time, presents it to the
// decoder until commit, then redirects. Stalled memory or bad targets halt.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic        is_jump,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic        is_jump_reg,
    input  logic [31:0] jump_reg_target,
    input  logic [15:0] imm16,
    input  logic [25:0] addr26,
    output logic        fetch_error
);

    // The counter holds misses already seen, so the last allowed miss is
    // the one that finds it at TIMEOUT_CYCLES-1.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t       state_reg;
    logic [31:0]        pc_reg;
    logic [31:0]        instruction_reg;
    logic               fetch_error_reg;
    logic               imem_req_reg;
    logic               instr_valid_reg;
    logic [TIMER_W-1:0] timer_reg;

    logic [31:0] pc_plus4_next;
    logic [31:0] next_pc;
    logic        next_pc_misaligned;

    assign pc_plus4_next = pc_reg + 32'd4;

    instruction_fetch_next_pc_calc u_next_pc_calc (
        .pc_plus4        (pc_plus4_next),
        .is_jump         (is_jump),
        .is_branch       (is_branch),
        .branch_taken    (branch_taken),
        .is_jump_reg     (is_jump_reg),
        .jump_reg_target (jump_reg_target),
        .imm16           (imm16),
        .addr26          (addr26),
        .next_pc         (next_pc),
        .misaligned      (next_pc_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= FETCH_S;
            pc_reg          <= RESET_PC;
            instruction_reg <= 32'd0;
            fetch_error_reg <= 1'b0;
            imem_req_reg    <= 1'b1;
            instr_valid_reg <= 1'b0;
            timer_reg       <= '0;
        end else begin
            case (state_reg)
                FETCH_S: begin
                    if (imem_ready) begin
                        instruction_reg <= imem_data;
                        state_reg       <= EXEC_S;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end else if (timer_reg == TIMER_LAST) begin
                        fetch_error_reg <= 1'b1;
                        state_reg       <= HALT_S;
                        imem_req_reg    <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                EXEC_S: begin
                    if (commit) begin
                        instr_valid_reg <= 1'b0;
                        if (next_pc_misaligned) begin
                            fetch_error_reg <= 1'b1;
                            state_reg       <= HALT_S;
                        end else begin
                            pc_reg       <= next_pc;
                            timer_reg    <= '0;
                            state_reg    <= FETCH_S;
                            imem_req_reg <= 1'b1;
                        end
                    end
                end
                HALT_S: begin
                    state_reg <= HALT_S;
                end
                default: begin
                    // Unused encoding: fail safe into the halted state.
                    fetch_error_reg <= 1'b1;
                    state_reg       <= HALT_S;
                    imem_req_reg    <= 1'b0;
                    instr_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_reg;
    assign imem_addr   = pc_reg;
    assign instruction = instruction_reg;
    assign instr_valid = instr_valid_reg;
    assign pc          = pc_reg;
    assign pc_plus4    = pc_plus4_next;
    assign fetch_error = fetch_error_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, all compared against a behavioural model every cycle.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int T_MAIN = 8;
    localparam int T_SHORT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic        commit = 1'b0;
    logic        is_jump = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic        is_jump_reg = 1'b0;
    logic [31:0] jump_reg_target = 32'd0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] addr26 = 26'd0;

    logic        imem_req, instr_valid, fetch_error;
    logic [31:0] imem_addr, instruction, pc, pc_plus4;
    logic        t4_imem_req, t4_instr_valid, t4_fetch_error;
    logic [31:0] t4_imem_addr, t4_instruction, t4_pc, t4_pc_plus4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, in plain terms.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_have_word;
    bit          m_halted;
    bit          m_err;
    int          m_misses;

    instruction_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(T_MAIN)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .instruction(instruction),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .commit(commit),
        .is_jump(is_jump), .is_branch(is_branch), .branch_taken(branch_taken),
        .is_jump_reg(is_jump_reg), .jump_reg_target(jump_reg_target),
        .imm16(imm16), .addr26(addr26), .fetch_error(fetch_error)
    );

    instruction_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(T_SHORT)) dut_t4 (
        .clk(clk), .reset(reset), .imem_req(t4_imem_req), .imem_addr(t4_imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .instruction(t4_instruction),
        .instr_valid(t4_instr_valid), .pc(t4_pc), .pc_plus4(t4_pc_plus4), .commit(commit),
        .is_jump(is_jump), .is_branch(is_branch), .branch_taken(branch_taken),
        .is_jump_reg(is_jump_reg), .jump_reg_target(jump_reg_target),
        .imm16(imm16), .addr26(addr26), .fetch_error(t4_fetch_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [31:0] cur_pc);
        logic [31:0] seq;
        int          words;
        seq = cur_pc + 32'd4;
        if (is_jump_reg) return jump_reg_target;
        if (is_jump) return (seq & 32'hF000_0000) | ({6'd0, addr26} * 32'd4);
        if (is_branch && branch_taken) begin
            words = int'($signed(imm16));
            return seq + 32'(words * 4);
        end
        return seq;
    endfunction

    task automatic model_update();
        logic [31:0] tgt;
        if (reset) begin
            m_pc = RESET_PC; m_instr = 32'd0; m_have_word = 0;
            m_halted = 0; m_err = 0; m_misses = 0;
        end else if (m_halted) begin
            // frozen
        end else if (!m_have_word) begin
            if (imem_ready) begin
                m_instr = imem_data;
                m_have_word = 1;
            end else begin
                m_misses++;
                if (m_misses == T_MAIN) begin
                    m_err = 1; m_halted = 1;
                end
            end
        end else if (commit) begin
            tgt = model_target(m_pc);
            m_have_word = 0;
            if (tgt % 4 != 0) begin
                m_err = 1; m_halted = 1;
                $display("commit pc %h -> misaligned %h, halt", m_pc, tgt);
            end else begin
                $display("commit pc %h -> %h", m_pc, tgt);
                m_pc = tgt; m_misses = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("imem_addr", imem_addr, m_pc);
        check("imem_req", {31'd0, imem_req}, {31'd0, !m_halted && !m_have_word});
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_have_word});
        check("fetch_error", {31'd0, fetch_error}, {31'd0, m_err});
        check("instruction", instruction, m_instr);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic clear_flags();
        commit = 0; is_jump = 0; is_branch = 0; branch_taken = 0;
        is_jump_reg = 0; jump_reg_target = 32'd0; imm16 = 16'd0; addr26 = 26'd0;
    endtask

    task automatic do_reset();
        clear_flags();
        imem_ready = 0;
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic fetch_word(input logic [31:0] data, input int delay);
        imem_ready = 0;
        for (int i = 0; i < delay; i++) step();
        imem_ready = 1; imem_data = data;
        step();
        imem_ready = 0;
    endtask

    task automatic do_commit(input bit jr, input logic [31:0] jr_tgt, input bit jmp,
                             input logic [25:0] a26, input bit br, input bit taken,
                             input logic [15:0] imm);
        is_jump_reg = jr; jump_reg_target = jr_tgt; is_jump = jmp; addr26 = a26;
        is_branch = br; branch_taken = taken; imm16 = imm; commit = 1;
        step();
        clear_flags();
    endtask

    task automatic goto_pc(input logic [31:0] target);
        fetch_word(32'h0000_0000, 0);
        do_commit(1, target, 0, 26'd0, 0, 0, 16'd0);
    endtask

    initial begin
        logic [31:0] a0;
        // Basic reset and single-cycle fetch.
        do_reset();
        check("rst_addr", imem_addr, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd1);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        fetch_word(32'h2001_0005, 0);
        check("fetch_word", instruction, 32'h2001_0005);
        check("fetch_valid", {31'd0, instr_valid}, 32'd1);
        do_commit(0, 0, 0, 0, 0, 0, 0);
        check("seq_pc", pc, 32'h4);

        // Branches.
        goto_pc(32'h100);
        fetch_word(32'h1111_1111, 0);
        do_commit(0, 0, 0, 0, 1, 1, 16'hFFFE);
        check("br_taken", pc, 32'h0FC);
        goto_pc(32'h100);
        fetch_word(32'h2222_2222, 0);
        do_commit(0, 0, 0, 0, 1, 0, 16'hFFFE);
        check("br_not_taken", pc, 32'h104);

        // Jumps and priority.
        goto_pc(32'h1000_0000);
        fetch_word(32'h3333_3333, 0);
        do_commit(0, 0, 1, 26'h000_0040, 0, 0, 0);
        check("jump", pc, 32'h1000_0100);
        goto_pc(32'h1000_0000);
        fetch_word(32'h4444_4444, 0);
        do_commit(1, 32'h200, 1, 26'h000_0040, 1, 1, 16'h0003);
        check("jreg_priority", pc, 32'h200);

        // Wrap-around of pc_plus4 and sequential flow.
        goto_pc(32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        fetch_word(32'h5555_5555, 0);
        do_commit(0, 0, 0, 0, 0, 0, 0);
        check("wrap_pc", pc, 32'h0);

        // Slow memory: 7 cycles of stall, address held, no fault.
        a0 = imem_addr;
        imem_ready = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_addr", imem_addr, a0);
        end
        imem_ready = 1; imem_data = 32'h6666_6666;
        step();
        imem_ready = 0;
        check("stall_err", {31'd0, fetch_error}, 32'd0);
        check("stall_word", instruction, 32'h6666_6666);

        // Timeout on the short-timeout instance.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step();
            check("t4_err", {31'd0, t4_fetch_error}, {31'd0, i == 4});
            check("t4_req", {31'd0, t4_imem_req}, {31'd0, i != 4});
        end
        imem_ready = 1; imem_data = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_frozen_req", {31'd0, t4_imem_req}, 32'd0);
            check("t4_frozen_valid", {31'd0, t4_instr_valid}, 32'd0);
            check("t4_frozen_pc", t4_pc, RESET_PC);
            check("t4_frozen_instr", t4_instruction, 32'd0);
        end

        // Misaligned register jump.
        do_reset();
        goto_pc(32'h40);
        fetch_word(32'h8888_8888, 0);
        do_commit(1, 32'h202, 0, 0, 0, 0, 0);
        check("mis_err", {31'd0, fetch_error}, 32'd1);
        check("mis_pc", pc, 32'h40);
        check("mis_valid", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1;
        for (int i = 0; i < 3; i++) do_commit(0, 0, 0, 0, 0, 0, 0);
        imem_ready = 0;

        // Reset while holding a word in EXEC with memory ready.
        do_reset();
        fetch_word(32'h9999_9999, 0);
        for (int i = 0; i < 20; i++) step();
        imem_ready = 1; imem_data = 32'hDEAD_BEEF; reset = 1;
        step();
        reset = 0; imem_ready = 0;
        check("rst_exec_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_exec_pc", pc, RESET_PC);
        check("rst_exec_instr", instruction, 32'd0);

        // Randomized traffic.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int halted_for;
            halted_for = 0;
            imem_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) imem_ready = 0;
            imem_data = $urandom;
            commit = ($urandom_range(0, 2) == 0);
            is_jump_reg = ($urandom_range(0, 5) == 0);
            is_jump = ($urandom_range(0, 4) == 0);
            is_branch = ($urandom_range(0, 2) == 0);
            branch_taken = $urandom_range(0, 1);
            jump_reg_target = $urandom;
            if ($urandom_range(0, 15) != 0) jump_reg_target[1:0] = 2'b00;
            imm16 = 16'($urandom);
            addr26 = 26'($urandom);
            reset = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
            step();
            reset = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
